// File: rtl/mc_cfg_pkg.sv
// Shared constants for the multi-channel APB configuration block: register map,
// reset defaults and the per-channel commit state encoding.
package mc_cfg_pkg;

    localparam logic [4:0] OFF_CTRL = 5'h00;
    localparam logic [4:0] OFF_TIM0 = 5'h04;
    localparam logic [4:0] OFF_TIM1 = 5'h08;
    localparam logic [4:0] OFF_RFST = 5'h0C;
    localparam logic [4:0] OFF_RFPR = 5'h10;
    localparam logic [4:0] OFF_STAT = 5'h14;

    localparam logic [8:0] CH_STRIDE = 9'h020;
    localparam logic [8:0] ID_ADDR   = 9'h100;
    localparam logic [15:0] ID_MAGIC = 16'h4D43;
    localparam logic [7:0]  ID_REV   = 8'h02;

    localparam logic [7:0] DEF_TRC  = 8'd20;
    localparam logic [7:0] DEF_TRAS = 8'd14;
    localparam logic [7:0] DEF_TRP  = 8'd6;
    localparam logic [7:0] DEF_TRCD = 8'd7;
    localparam logic [7:0] DEF_TWR  = 8'd6;
    localparam logic [7:0] DEF_TRTP = 8'd2;

    localparam logic [31:0] DEF_TIM0      = {DEF_TRCD, DEF_TRP, DEF_TRAS, DEF_TRC};
    localparam logic [15:0] DEF_TIM1      = {DEF_TRTP, DEF_TWR};
    // All-ones start time keeps refresh disabled until software programs it.
    localparam logic [31:0] DEF_RF_START  = 32'hFFFF_FFFF;
    localparam logic [31:0] DEF_RF_PERIOD = 32'd25600000;

    typedef enum logic {ST_IDLE, ST_PEND} cfg_st_e;

    function automatic logic [31:0] id_value(input int ch_num);
        return {ID_MAGIC, 8'(ch_num), ID_REV};
    endfunction

endpackage

// File: rtl/mc_cfg_chan.sv
// One channel: shadow and active timing/refresh registers, enable, sticky lock
// and the commit FSM that copies shadow to active while the controller is idle.
module mc_cfg_chan
    import mc_cfg_pkg::*;
#(
    parameter int RF_W = 28
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_wr_ctrl,
    input  logic            i_wr_tim0,
    input  logic            i_wr_tim1,
    input  logic            i_wr_rfst,
    input  logic            i_wr_rfpr,
    input  logic [31:0]     i_wdata,
    input  logic            i_idle,
    output logic            o_en,
    output logic            o_lock,
    output logic            o_pending,
    output logic            o_update,
    output logic [31:0]     o_rd_tim0,
    output logic [15:0]     o_rd_tim1,
    output logic [RF_W-1:0] o_rd_rfst,
    output logic [RF_W-1:0] o_rd_rfpr,
    output logic [7:0]      o_trc,
    output logic [7:0]      o_tras,
    output logic [7:0]      o_trp,
    output logic [7:0]      o_trcd,
    output logic [7:0]      o_twr,
    output logic [7:0]      o_trtp,
    output logic [RF_W-1:0] o_rf_start,
    output logic [RF_W-1:0] o_rf_period
);

    logic [31:0]     r_sh_tim0, r_act_tim0;
    logic [15:0]     r_sh_tim1, r_act_tim1;
    logic [RF_W-1:0] r_sh_rfst, r_act_rfst;
    logic [RF_W-1:0] r_sh_rfpr, r_act_rfpr;
    logic            r_en, r_lock, r_upd;
    cfg_st_e         r_state, w_state_nxt;
    logic            w_apply, w_commit;

    assign w_commit = i_wr_ctrl & i_wdata[1];

    always_comb begin
        w_state_nxt = r_state;
        w_apply     = 1'b0;
        case (r_state)
            ST_IDLE: if (w_commit) w_state_nxt = ST_PEND;
            ST_PEND: begin
                if (i_idle) begin
                    w_apply = 1'b1;
                    // A commit landing on the apply edge re-arms for another pass.
                    if (!w_commit) w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_en       <= 1'b0;
            r_lock     <= 1'b0;
            r_upd      <= 1'b0;
            r_sh_tim0  <= DEF_TIM0;
            r_sh_tim1  <= DEF_TIM1;
            r_sh_rfst  <= DEF_RF_START[RF_W-1:0];
            r_sh_rfpr  <= DEF_RF_PERIOD[RF_W-1:0];
            r_act_tim0 <= DEF_TIM0;
            r_act_tim1 <= DEF_TIM1;
            r_act_rfst <= DEF_RF_START[RF_W-1:0];
            r_act_rfpr <= DEF_RF_PERIOD[RF_W-1:0];
        end else begin
            r_state <= w_state_nxt;
            r_upd   <= w_apply;
            if (i_wr_ctrl) begin
                r_en <= i_wdata[0];
                if (i_wdata[31]) r_lock <= 1'b1;
            end
            if (i_wr_tim0) r_sh_tim0 <= i_wdata;
            if (i_wr_tim1) r_sh_tim1 <= i_wdata[15:0];
            if (i_wr_rfst) r_sh_rfst <= i_wdata[RF_W-1:0];
            if (i_wr_rfpr) r_sh_rfpr <= i_wdata[RF_W-1:0];
            // Non-blocking copy: a shadow write on this edge is not seen here.
            if (w_apply) begin
                r_act_tim0 <= r_sh_tim0;
                r_act_tim1 <= r_sh_tim1;
                r_act_rfst <= r_sh_rfst;
                r_act_rfpr <= r_sh_rfpr;
            end
        end
    end

    assign o_en        = r_en;
    assign o_lock      = r_lock;
    assign o_pending   = (r_state == ST_PEND);
    assign o_update    = r_upd;
    assign o_rd_tim0   = r_sh_tim0;
    assign o_rd_tim1   = r_sh_tim1;
    assign o_rd_rfst   = r_sh_rfst;
    assign o_rd_rfpr   = r_sh_rfpr;
    assign o_trc       = r_act_tim0[7:0];
    assign o_tras      = r_act_tim0[15:8];
    assign o_trp       = r_act_tim0[23:16];
    assign o_trcd      = r_act_tim0[31:24];
    assign o_twr       = r_act_tim1[7:0];
    assign o_trtp      = r_act_tim1[15:8];
    assign o_rf_start  = r_act_rfst;
    assign o_rf_period = r_act_rfpr;

endmodule

// File: rtl/mc_apb_cfg_mch.sv
// APB3 front end for CH_NUM controller channels: address decode, registered read
// mux and error response (enabled by defining MC_APB_PSLVERR_EN).
module mc_apb_cfg_mch
    import mc_cfg_pkg::*;
#(
    parameter int CH_NUM = 2,
    parameter int RF_W   = 28
) (
    input  logic                   apb_pclk,
    input  logic                   apb_prstn,
    input  logic                   apb_psel,
    input  logic                   apb_penable,
    input  logic                   apb_pwrite,
    input  logic [31:0]            apb_addr,
    input  logic [31:0]            apb_pwdata,
    output logic [31:0]            apb_prdata,
    output logic                   apb_pready,
    output logic                   apb_pslverr,
    input  logic [CH_NUM-1:0]      mc_idle,
    output logic [CH_NUM-1:0]      mc_en,
    output logic [8*CH_NUM-1:0]    mc_trc_cfg,
    output logic [8*CH_NUM-1:0]    mc_tras_cfg,
    output logic [8*CH_NUM-1:0]    mc_trp_cfg,
    output logic [8*CH_NUM-1:0]    mc_trcd_cfg,
    output logic [8*CH_NUM-1:0]    mc_twr_cfg,
    output logic [8*CH_NUM-1:0]    mc_trtp_cfg,
    output logic [RF_W*CH_NUM-1:0] mc_rf_start_time_cfg,
    output logic [RF_W*CH_NUM-1:0] mc_rf_period_time_cfg,
    output logic [CH_NUM-1:0]      mc_cfg_update
);

    logic [4:0]                   w_off;
    logic                         w_acc, w_id_hit, w_ch_hit, w_off_ok, w_map;
    logic                         w_sel_lock, w_wr_ro, w_wr_lk, w_err, w_wr_ok;
    logic [31:0]                  w_ch_rdata, w_rdata, r_prdata;
    logic [CH_NUM-1:0]            w_ch_sel, w_lock, w_pending;
    logic [CH_NUM-1:0][31:0]      w_rd_tim0;
    logic [CH_NUM-1:0][15:0]      w_rd_tim1;
    logic [CH_NUM-1:0][RF_W-1:0]  w_rd_rfst, w_rd_rfpr;
    logic                         w_unused;

    assign w_unused = &{1'b0, apb_addr[31:9]};
    assign w_off    = apb_addr[4:0];
    assign w_acc    = apb_psel & apb_penable;
    assign w_id_hit = (apb_addr[8:0] == ID_ADDR);
    assign w_ch_hit = |w_ch_sel;
    // Only word-aligned, defined offsets are mapped; this also rejects addr[1:0] != 0.
    assign w_off_ok = (w_off == OFF_CTRL) | (w_off == OFF_TIM0) | (w_off == OFF_TIM1) |
                      (w_off == OFF_RFST) | (w_off == OFF_RFPR) | (w_off == OFF_STAT);
    assign w_map    = w_id_hit | (w_ch_hit & w_off_ok);
    assign w_wr_ro  = apb_pwrite & (w_id_hit | (w_ch_hit & (w_off == OFF_STAT)));
    assign w_wr_lk  = apb_pwrite & w_ch_hit & w_sel_lock &
                      ((w_off == OFF_TIM0) | (w_off == OFF_TIM1) |
                       (w_off == OFF_RFST) | (w_off == OFF_RFPR));
    assign w_err    = ~w_map | w_wr_ro | w_wr_lk;
    assign w_wr_ok  = w_acc & apb_pwrite & ~w_err;

    for (genvar g = 0; g < CH_NUM; g++) begin : g_ch
        assign w_ch_sel[g] = ((apb_addr[8:0] & 9'h1E0) == 9'(g) * CH_STRIDE);

        mc_cfg_chan #(.RF_W(RF_W)) u_chan (
            .clk         (apb_pclk),
            .rst_n       (apb_prstn),
            .i_wr_ctrl   (w_wr_ok & w_ch_sel[g] & (w_off == OFF_CTRL)),
            .i_wr_tim0   (w_wr_ok & w_ch_sel[g] & (w_off == OFF_TIM0)),
            .i_wr_tim1   (w_wr_ok & w_ch_sel[g] & (w_off == OFF_TIM1)),
            .i_wr_rfst   (w_wr_ok & w_ch_sel[g] & (w_off == OFF_RFST)),
            .i_wr_rfpr   (w_wr_ok & w_ch_sel[g] & (w_off == OFF_RFPR)),
            .i_wdata     (apb_pwdata),
            .i_idle      (mc_idle[g]),
            .o_en        (mc_en[g]),
            .o_lock      (w_lock[g]),
            .o_pending   (w_pending[g]),
            .o_update    (mc_cfg_update[g]),
            .o_rd_tim0   (w_rd_tim0[g]),
            .o_rd_tim1   (w_rd_tim1[g]),
            .o_rd_rfst   (w_rd_rfst[g]),
            .o_rd_rfpr   (w_rd_rfpr[g]),
            .o_trc       (mc_trc_cfg[8*g +: 8]),
            .o_tras      (mc_tras_cfg[8*g +: 8]),
            .o_trp       (mc_trp_cfg[8*g +: 8]),
            .o_trcd      (mc_trcd_cfg[8*g +: 8]),
            .o_twr       (mc_twr_cfg[8*g +: 8]),
            .o_trtp      (mc_trtp_cfg[8*g +: 8]),
            .o_rf_start  (mc_rf_start_time_cfg[RF_W*g +: RF_W]),
            .o_rf_period (mc_rf_period_time_cfg[RF_W*g +: RF_W])
        );
    end

    always_comb begin
        w_ch_rdata = '0;
        w_sel_lock = 1'b0;
        for (int n = 0; n < CH_NUM; n++) begin
            if (w_ch_sel[n]) begin
                w_sel_lock = w_lock[n];
                case (w_off)
                    OFF_CTRL: w_ch_rdata = {w_lock[n], 30'b0, mc_en[n]};
                    OFF_TIM0: w_ch_rdata = w_rd_tim0[n];
                    OFF_TIM1: w_ch_rdata = {16'b0, w_rd_tim1[n]};
                    OFF_RFST: w_ch_rdata = 32'(w_rd_rfst[n]);
                    OFF_RFPR: w_ch_rdata = 32'(w_rd_rfpr[n]);
                    OFF_STAT: w_ch_rdata = {31'b0, w_pending[n]};
                    default:  w_ch_rdata = '0;
                endcase
            end
        end
    end

    assign w_rdata = w_id_hit ? id_value(CH_NUM) : w_ch_rdata;

    // Captured in SETUP so the data is stable for the whole ACCESS phase.
    always_ff @(posedge apb_pclk or negedge apb_prstn) begin
        if (!apb_prstn)                                   r_prdata <= '0;
        else if (apb_psel & ~apb_penable & ~apb_pwrite)   r_prdata <= w_rdata;
    end

    assign apb_prdata = r_prdata;
    assign apb_pready = 1'b1;

`ifdef MC_APB_PSLVERR_EN
    assign apb_pslverr = w_acc & w_err;
`else
    assign apb_pslverr = 1'b0;
`endif

endmodule

// File: doc/mc_apb_cfg_mch.md
# mc_apb_cfg_mch

Parametrised APB3 configuration block for the multi-channel memory controller. It holds per-channel DRAM timing and refresh settings in shadow registers. Each channel applies its shadow values to its active outputs atomically, after software commits and only while that channel's controller reports idle. It sits between the APB interconnect and the `CH_NUM` controller channel cores, and replaces the single-channel configuration block.

## Interface
- `CH_NUM`, 2: number of controller channels, legal range 1..8.
- `RF_W`, 28: refresh start/period field width, legal range 1..32.
- `apb_pclk` in 1: clock.
- `apb_prstn` in 1: asynchronous, active-low reset.
- `apb_psel`, `apb_penable`, `apb_pwrite` in 1 each: APB control signals.
- `apb_addr` in 32: byte address; only bits [8:0] are decoded.
- `apb_pwdata` in 32: write data.
- `apb_prdata` out 32: read data.
- `apb_pready` out 1: always 1 (zero wait states).
- `apb_pslverr` out 1: error response; see Configuration.
- `mc_idle` in CH_NUM: per-channel "controller idle, safe to retime".
- `mc_en` out CH_NUM: per-channel enable; not shadowed.
- `mc_trc_cfg`, `mc_tras_cfg`, `mc_trp_cfg`, `mc_trcd_cfg`, `mc_twr_cfg`, `mc_trtp_cfg` out 8*CH_NUM: active timings, channel n at bits [8n+7:8n].
- `mc_rf_start_time_cfg`, `mc_rf_period_time_cfg` out RF_W*CH_NUM: active refresh settings.
- `mc_cfg_update` out CH_NUM: one-cycle pulse when the active set loads.

## Operation
- Channel n base address is n*0x20. Register offsets within a channel:
  - 0x00 CTRL: bit0 `en` (RW). bit1 `commit` (write 1 to request; reads 0). bit31 `lock` (write 1 sets it; sticky until reset).
  - 0x04 TIM0: {trcd, trp, tras, trc}, bytes 3..0 (RW, shadow).
  - 0x08 TIM1: {16'b0, trtp, twr} (RW, shadow).
  - 0x0C RFST: start[RF_W-1:0] (RW, shadow).
  - 0x10 RFPR: period[RF_W-1:0] (RW, shadow).
  - 0x14 STAT: bit0 `pending` (RO).
- Global 0x100 ID (RO) = {16'h4D43, 8'(CH_NUM), 8'h02}.
- Reset values:
  - Shadow and active alike: trc 20, tras 14, trp 6, trcd 7, twr 6, trtp 2, rf_start all-ones (refresh off), rf_period 25600000 truncated to RF_W.
  - `en` 0, `lock` 0, `pending` 0.
  - `apb_prdata` 0, `apb_pslverr` 0, `mc_cfg_update` 0.
- Write: takes effect at the ACCESS-phase edge (psel & penable & pwrite). Writes to TIM0..RFPR are ignored while `lock` is set. Unused data bits are dropped.
- Read: `apb_prdata` is registered in the SETUP phase (psel & !penable & !pwrite) and is valid in ACCESS. TIM/RF registers read back shadow values. Unmapped addresses read 0.
- Per-channel commit FSM:
  - IDLE → PEND on a commit write. `commit` is honoured even while `lock` is set.
  - PEND → IDLE at the first edge where `mc_idle[n]` = 1. At that edge the active registers load the shadow registers, and `mc_cfg_update[n]` = 1 for the following cycle.
  - `pending` = (state == PEND).
- Boundary rules:
  - Shadow write at the apply edge: active takes the pre-write shadow value; the new value waits for the next commit.
  - Commit write at the apply edge: state stays PEND and the channel applies again at the next idle edge.
  - Repeated commits while in PEND: no effect.
  - `mc_idle` low forever: stays in PEND; no timeout.
  - Reset mid-PEND: returns to IDLE; all registers return to their defaults.

## Timing
- Writes complete with zero wait states; the register updates at the ACCESS edge E0.
- Commit written at E0 with `mc_idle` high: active outputs change after E1; `mc_cfg_update` is high from E1 to E2.
- `mc_en` changes directly after E0.
- Read data is registered one edge before ACCESS.

## Configuration
- `MC_APB_PSLVERR_EN` defined:
  - `apb_pslverr` = 1 during ACCESS for: unmapped address; `apb_addr[1:0]` ≠ 0; write to STAT or ID; TIM/RF write while `lock` is set.
  - The erroring write has no effect.
- `MC_APB_PSLVERR_EN` undefined: `apb_pslverr` is tied 0; the same accesses are silently ignored.

## Structure
- Package `mc_cfg_pkg` holds:
  - register offset localparams, channel stride 0x20, ID address and value;
  - reset-default constants;
  - FSM state enum {ST_IDLE, ST_PEND}.
- Sub-module `mc_cfg_chan`: one channel's shadow, active, lock, en and FSM. It is instantiated CH_NUM times in a generate loop. The top level holds APB decode, read mux and pslverr.

## Test plan
- Reset, then read ch0 TIM0 → 0x07060E14; ID → 0x4D430202; all outputs at their defaults.
- Write ch1 TIM0 = 0x0A0B0C0D with `mc_idle`=1 and no commit → outputs unchanged. Then commit → ch1 trc = 0x0D after two edges, one `mc_cfg_update[1]` pulse, ch0 outputs untouched.
- Hold `mc_idle[0]`=0, write RFPR = 1000, then commit → STAT reads 1 and outputs are held. Raise idle → period = 1000, STAT reads 0.
- Set ch0 `lock`, then write TIM1 = 0x0303 → readback unchanged, pslverr = 1 (macro on) or 0 (macro off).
- Write shadow on the same edge as apply → active holds the old value, new value in shadow. Assert reset while in PEND → defaults restored, pending 0.
- Read 0x0FC and 0x002 → prdata 0; pslverr = 1 with the macro on.
